// File: rtl/mc_controller_if.sv
// Control bus between the multicycle datapath and mc_controller.
// master = datapath side, slave = controller side.
interface mc_controller_if;
   logic [6:0] op;
   logic [2:0] funct3;
   logic       funct7b5;
   logic       zero;
   logic       mem_ready;
   logic       pc_write;
   logic       ir_write;
   logic       mem_write;
   logic       reg_write;
   logic       adr_src;
   logic [1:0] alu_src_a;
   logic [1:0] alu_src_b;
   logic [1:0] result_src;
   logic [1:0] imm_src;
   logic [2:0] alu_control;

   modport master (
      output op, funct3, funct7b5, zero, mem_ready,
      input  pc_write, ir_write, mem_write, reg_write, adr_src,
      input  alu_src_a, alu_src_b, result_src, imm_src, alu_control
   );

   modport slave (
      input  op, funct3, funct7b5, zero, mem_ready,
      output pc_write, ir_write, mem_write, reg_write, adr_src,
      output alu_src_a, alu_src_b, result_src, imm_src, alu_control
   );
endinterface

// File: rtl/mc_controller.sv
// Moore-style multicycle RISC-V control FSM with ALU and immediate decoders.
// Define MC_CONTROLLER_BNE_EN to let BRANCH also take bne (funct3=001, zero=0).
module mc_controller (
   input  logic                  clk,
   input  logic                  reset,
   mc_controller_if.slave        bus
);

   typedef enum logic [3:0] {
      FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
      EXECR, EXECI, ALUWB, BRANCH, JAL
   } state_t;

   typedef enum logic [1:0] {
      ALU_ADD, ALU_SUB, ALU_FUNCT
   } alu_op_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   state_t     state, state_next;
   alu_op_t    alu_op;
   logic       branch_taken;
   logic       pc_write, ir_write, mem_write, reg_write, adr_src;
   logic [1:0] alu_src_a, alu_src_b, result_src, imm_src;
   logic [2:0] alu_control;

   always_ff @(posedge clk) begin
      if (reset) state <= FETCH;
      else       state <= state_next;
   end

`ifdef MC_CONTROLLER_BNE_EN
   assign branch_taken = ((bus.funct3 == 3'b000) &&  bus.zero) ||
                         ((bus.funct3 == 3'b001) && !bus.zero);
`else
   assign branch_taken = (bus.funct3 == 3'b000) && bus.zero;
`endif

   always_comb begin
      state_next = state;
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      adr_src    = 1'b0;
      alu_src_a  = '0;
      alu_src_b  = '0;
      result_src = '0;
      alu_op     = ALU_ADD;
      case (state)
         FETCH: begin
            alu_src_b  = 2'b10;
            result_src = 2'b10;
            if (bus.mem_ready) begin
               ir_write   = 1'b1;
               pc_write   = 1'b1;
               state_next = DECODE;
            end
         end
         DECODE: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b01;
            case (bus.op)
               OP_LOAD, OP_STORE: state_next = MEMADR;
               OP_RTYPE:          state_next = EXECR;
               OP_ITYPE:          state_next = EXECI;
               OP_BRANCH:         state_next = BRANCH;
               OP_JAL:            state_next = JAL;
               default:           state_next = FETCH;
            endcase
         end
         MEMADR: begin
            alu_src_a  = 2'b10;
            alu_src_b  = 2'b01;
            state_next = (bus.op == OP_LOAD) ? MEMREAD : MEMWRITE;
         end
         MEMREAD: begin
            adr_src = 1'b1;
            if (bus.mem_ready) state_next = MEMWB;
         end
         MEMWB: begin
            result_src = 2'b01;
            reg_write  = 1'b1;
            state_next = FETCH;
         end
         MEMWRITE: begin
            adr_src    = 1'b1;
            mem_write  = 1'b1;
            state_next = FETCH;
         end
         EXECR: begin
            alu_src_a  = 2'b10;
            alu_op     = ALU_FUNCT;
            state_next = ALUWB;
         end
         EXECI: begin
            alu_src_a  = 2'b10;
            alu_src_b  = 2'b01;
            alu_op     = ALU_FUNCT;
            state_next = ALUWB;
         end
         ALUWB: begin
            reg_write  = 1'b1;
            state_next = FETCH;
         end
         BRANCH: begin
            alu_src_a  = 2'b10;
            alu_op     = ALU_SUB;
            pc_write   = branch_taken;
            state_next = FETCH;
         end
         JAL: begin
            alu_src_a  = 2'b01;
            alu_src_b  = 2'b10;
            pc_write   = 1'b1;
            state_next = ALUWB;
         end
         default: state_next = FETCH;
      endcase

      // Outputs follow reset immediately, even before the state register
      // has been forced back to FETCH.
      if (reset) begin
         pc_write   = 1'b0;
         ir_write   = 1'b0;
         mem_write  = 1'b0;
         reg_write  = 1'b0;
         adr_src    = 1'b0;
         alu_src_a  = 2'b00;
         alu_src_b  = 2'b10;
         result_src = 2'b10;
         alu_op     = ALU_ADD;
      end
   end

   always_comb begin
      alu_control = 3'b000;
      case (alu_op)
         ALU_ADD: alu_control = 3'b000;
         ALU_SUB: alu_control = 3'b001;
         default: begin
            case (bus.funct3)
               3'b000:  alu_control = ((bus.op == OP_RTYPE) && bus.funct7b5) ? 3'b001 : 3'b000;
               3'b010:  alu_control = 3'b101;
               3'b110:  alu_control = 3'b011;
               3'b111:  alu_control = 3'b010;
               default: alu_control = 3'b000;
            endcase
         end
      endcase
   end

   always_comb begin
      case (bus.op)
         OP_STORE:  imm_src = 2'b01;
         OP_BRANCH: imm_src = 2'b10;
         OP_JAL:    imm_src = 2'b11;
         default:   imm_src = 2'b00;
      endcase
   end

   assign bus.pc_write    = pc_write;
   assign bus.ir_write    = ir_write;
   assign bus.mem_write   = mem_write;
   assign bus.reg_write   = reg_write;
   assign bus.adr_src     = adr_src;
   assign bus.alu_src_a   = alu_src_a;
   assign bus.alu_src_b   = alu_src_b;
   assign bus.result_src  = result_src;
   assign bus.imm_src     = imm_src;
   assign bus.alu_control = alu_control;

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: every output is packed into one word and
// compared against hand-written per-state values.
module tb_mc_controller;

   logic clk;
   logic reset;
   int   checks;
   int   errors;

   mc_controller_if bus ();

   mc_controller dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // {imm_src, pc_write, ir_write, mem_write, reg_write, adr_src,
   //  alu_src_a, alu_src_b, result_src, alu_control}
   logic [15:0] got;
   assign got = {bus.imm_src, bus.pc_write, bus.ir_write, bus.mem_write,
                 bus.reg_write, bus.adr_src, bus.alu_src_a, bus.alu_src_b,
                 bus.result_src, bus.alu_control};

   function automatic logic [15:0] sig(input logic [1:0] imm,
                                       input logic pcw, input logic irw,
                                       input logic mw,  input logic rw,
                                       input logic adr,
                                       input logic [1:0] a, input logic [1:0] b,
                                       input logic [1:0] res,
                                       input logic [2:0] alu);
      return {imm, pcw, irw, mw, rw, adr, a, b, res, alu};
   endfunction

   task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Called while in FETCH with mem_ready=1; leaves the DUT in DECODE.
   task automatic fetch_decode(input string tag, input logic [6:0] o,
                               input logic [2:0] f3, input logic f7,
                               input logic [1:0] imm);
      bus.op       = o;
      bus.funct3   = f3;
      bus.funct7b5 = f7;
      #1 check({tag, "_fetch"}, got, sig(imm, 1, 1, 0, 0, 0, 2'b00, 2'b10, 2'b10, 3'b000));
      cyc();
      check({tag, "_decode"}, got, sig(imm, 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 3'b000));
   endtask

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BR  = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;
   localparam logic [6:0] OP_BAD = 7'b1111111;

`ifdef MC_CONTROLLER_BNE_EN
   localparam logic BNE_PCW = 1'b1;
`else
   localparam logic BNE_PCW = 1'b0;
`endif

   initial begin
      checks        = 0;
      errors        = 0;
      reset         = 1'b1;
      bus.op        = OP_LW;
      bus.funct3    = 3'b010;
      bus.funct7b5  = 1'b0;
      bus.zero      = 1'b0;
      bus.mem_ready = 1'b1;

      // Reset held three cycles: FETCH selects, no write enables.
      for (int i = 0; i < 3; i++) begin
         cyc();
         check("reset", got, sig(2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b10, 3'b000));
      end
      reset = 1'b0;

      // lw
      fetch_decode("lw", OP_LW, 3'b010, 1'b0, 2'b00);
      cyc(); check("lw_memadr",  got, sig(2'b00, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 3'b000));
      cyc(); check("lw_memread", got, sig(2'b00, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000));
      cyc(); check("lw_memwb",   got, sig(2'b00, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b01, 3'b000));
      cyc(); check("lw_back",    got, sig(2'b00, 1, 1, 0, 0, 0, 2'b00, 2'b10, 2'b10, 3'b000));

      // Fetch stall for four cycles, then an unknown opcode.
      bus.op        = OP_BAD;
      bus.mem_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1 check("stall", got, sig(2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b10, 3'b000));
         cyc();
      end
      bus.mem_ready = 1'b1;
      #1 check("stall_go", got, sig(2'b00, 1, 1, 0, 0, 0, 2'b00, 2'b10, 2'b10, 3'b000));
      cyc(); check("bad_decode", got, sig(2'b00, 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 3'b000));
      cyc(); check("bad_back",   got, sig(2'b00, 1, 1, 0, 0, 0, 2'b00, 2'b10, 2'b10, 3'b000));

      // R-type sub, or, slt, and
      fetch_decode("sub", OP_R, 3'b000, 1'b1, 2'b00);
      cyc(); check("sub_execr", got, sig(2'b00, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00, 3'b001));
      cyc(); check("sub_aluwb", got, sig(2'b00, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 3'b000));
      cyc();
      fetch_decode("or", OP_R, 3'b110, 1'b0, 2'b00);
      cyc(); check("or_execr", got, sig(2'b00, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00, 3'b011));
      cyc(); cyc();
      fetch_decode("slt", OP_R, 3'b010, 1'b0, 2'b00);
      cyc(); check("slt_execr", got, sig(2'b00, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00, 3'b101));
      cyc(); cyc();
      fetch_decode("and", OP_R, 3'b111, 1'b0, 2'b00);
      cyc(); check("and_execr", got, sig(2'b00, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00, 3'b010));
      cyc(); cyc();

      // addi with funct7b5=1 must still add
      fetch_decode("addi", OP_I, 3'b000, 1'b1, 2'b00);
      cyc(); check("addi_execi", got, sig(2'b00, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 3'b000));
      cyc(); check("addi_aluwb", got, sig(2'b00, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 3'b000));
      cyc();

      // Branch: sweep funct3/zero inside the single BRANCH cycle.
      fetch_decode("br", OP_BR, 3'b000, 1'b0, 2'b10);
      cyc();
      bus.zero = 1'b1;
      #1 check("beq_taken", got, sig(2'b10, 1, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00, 3'b001));
      bus.zero = 1'b0;
      #1 check("beq_not",   got, sig(2'b10, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00, 3'b001));
      bus.funct3 = 3'b001;
      #1 check("bne_taken", got, sig(2'b10, BNE_PCW, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00, 3'b001));
      bus.zero = 1'b1;
      #1 check("bne_not",   got, sig(2'b10, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00, 3'b001));
      bus.funct3 = 3'b100;
      #1 check("blt_z1",    got, sig(2'b10, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00, 3'b001));
      bus.zero = 1'b0;
      #1 check("blt_z0",    got, sig(2'b10, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00, 3'b001));
      cyc(); check("br_back", got, sig(2'b10, 1, 1, 0, 0, 0, 2'b00, 2'b10, 2'b10, 3'b000));

      // sw: single mem_write cycle
      fetch_decode("sw", OP_SW, 3'b010, 1'b0, 2'b01);
      cyc(); check("sw_memadr",   got, sig(2'b01, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 3'b000));
      cyc(); check("sw_memwrite", got, sig(2'b01, 0, 0, 1, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000));
      cyc(); check("sw_back",     got, sig(2'b01, 1, 1, 0, 0, 0, 2'b00, 2'b10, 2'b10, 3'b000));

      // jal
      fetch_decode("jal", OP_JAL, 3'b000, 1'b0, 2'b11);
      cyc(); check("jal_jal",   got, sig(2'b11, 1, 0, 0, 0, 0, 2'b01, 2'b10, 2'b00, 3'b000));
      cyc(); check("jal_aluwb", got, sig(2'b11, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 3'b000));
      cyc(); check("jal_back",  got, sig(2'b11, 1, 1, 0, 0, 0, 2'b00, 2'b10, 2'b10, 3'b000));

      // Reset arriving while MEMREAD waits: no MEMWB afterwards.
      fetch_decode("lwr", OP_LW, 3'b010, 1'b0, 2'b00);
      cyc();
      cyc(); check("lwr_memread", got, sig(2'b00, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000));
      bus.mem_ready = 1'b0;
      cyc(); check("lwr_wait",    got, sig(2'b00, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000));
      reset = 1'b1;
      #1 check("lwr_rst_comb", got, sig(2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b10, 3'b000));
      cyc(); check("lwr_rst_edge", got, sig(2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b10, 3'b000));
      reset = 1'b0;
      #1 check("lwr_fetch_wait", got, sig(2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b10, 3'b000));
      bus.mem_ready = 1'b1;
      #1 check("lwr_fetch_go",   got, sig(2'b00, 1, 1, 0, 0, 0, 2'b00, 2'b10, 2'b10, 3'b000));
      cyc(); check("lwr_decode",  got, sig(2'b00, 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 3'b000));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 op  input  7  instruction opcode (instr[6:0]).
REQ-005 funct3  input  3  instr[14:12].
REQ-006 funct7b5  input  1  instr[30].
REQ-007 zero  input  1  ALU zero flag.
REQ-008 mem_ready  input  1  memory access complete this cycle.
REQ-009 pc_write, ir_write, mem_write, reg_write  output  1 each  write enables.
REQ-010 adr_src  output  1  address select: 0 = PC, 1 = Result.
REQ-011 alu_src_a  output  2  ALU A select: 00 = PC, 01 = OldPC, 10 = RD1.
REQ-012 alu_src_b  output  2  ALU B select: 00 = WriteData, 01 = ImmExt, 10 = constant 4.
REQ-013 result_src  output  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult.
REQ-014 imm_src  output  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J.
REQ-015 alu_control  output  3  000 = add, 001 = sub, 010 = and, 011 = or, 101 = slt.

Function
REQ-016 SHALL implement a Moore FSM with states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL; each transition takes one clk edge.
REQ-017 FETCH outputs: adr_src=0, alu_src_a=00, alu_src_b=10, alu_op=add, result_src=10. If mem_ready=1: ir_write=1, pc_write=1, next state DECODE. If mem_ready=0: ir_write=0, pc_write=0, remain in FETCH.
REQ-018 DECODE outputs: alu_src_a=01, alu_src_b=01, alu_op=add (branch target). Next state by op: 0000011/0100011 -> MEMADR; 0110011 -> EXECR; 0010011 -> EXECI; 1100011 -> BRANCH; 1101111 -> JAL; any other op -> FETCH with no write enable asserted.
REQ-019 MEMADR outputs: alu_src_a=10, alu_src_b=01, alu_op=add. Next state MEMREAD if op=0000011, otherwise MEMWRITE.
REQ-020 MEMREAD outputs: result_src=00, adr_src=1. Next state MEMWB on mem_ready=1; otherwise remain in MEMREAD.
REQ-021 MEMWB outputs: result_src=01, reg_write=1. Next state FETCH.
REQ-022 MEMWRITE outputs: result_src=00, adr_src=1, mem_write=1 for exactly one cycle. Next state FETCH.
REQ-023 EXECR outputs: alu_src_a=10, alu_src_b=00, alu_op=funct. EXECI outputs: alu_src_a=10, alu_src_b=01, alu_op=funct. Both go next to ALUWB.
REQ-024 ALUWB outputs: result_src=00, reg_write=1. Next state FETCH.
REQ-025 BRANCH outputs: alu_src_a=10, alu_src_b=00, alu_op=sub, result_src=00; pc_write is asserted when the branch is taken (REQ-034). Next state FETCH.
REQ-026 JAL outputs: alu_src_a=01, alu_src_b=10, alu_op=add, result_src=00, pc_write=1. Next state ALUWB.
REQ-027 Write enables, adr_src and any select not listed for a state SHALL be 0 / 00.
REQ-028 ALU decode: alu_op=add -> 000; alu_op=sub -> 001. For alu_op=funct: funct3 000 -> 001 if op=0110011 and funct7b5=1, else 000; 010 -> 101; 110 -> 011; 111 -> 010; any other funct3 -> 000.
REQ-029 imm_src is decoded combinationally from op alone: 0100011 -> 01, 1100011 -> 10, 1101111 -> 11, else 00.
REQ-030 All outputs SHALL be combinational functions of the state register, op, funct3, funct7b5, zero and mem_ready; there SHALL be no registered outputs.

Reset
REQ-031 reset=1 at a clk edge SHALL load state FETCH, including when it arrives mid-instruction.
REQ-032 While reset=1, pc_write, ir_write, mem_write and reg_write SHALL be 0; the select outputs take their FETCH values.
REQ-033 The first fetch SHALL occur on the first edge with reset=0 and mem_ready=1.

Configuration
REQ-034 With macro MC_CONTROLLER_BNE_EN defined, BRANCH asserts pc_write when (funct3=000 and zero=1) or (funct3=001 and zero=0). Without the macro, BRANCH asserts pc_write only when funct3=000 and zero=1. Any other funct3 SHALL never assert pc_write.

Verification
REQ-035 reset held 3 cycles, then lw (op=0000011) with mem_ready=1 -> states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, FETCH; reg_write=1 only in MEMWB, with result_src=01.
REQ-036 FETCH with mem_ready=0 for 4 cycles, then 1 -> ir_write=0 and pc_write=0 for 4 cycles, then ir_write=1 and pc_write=1 for one cycle, then DECODE.
REQ-037 R-type sub (funct3=000, funct7b5=1) -> alu_control=001 in EXECR; or -> 011; slt -> 101; addi with funct7b5=1 -> 000.
REQ-038 op=1100011, funct3=001, zero=0 -> pc_write=1 in BRANCH with the macro defined, 0 without it; funct3=000 with zero=1 -> pc_write=1 in both builds.
REQ-039 sw -> mem_write=1 for exactly one cycle with adr_src=1; op=1111111 -> DECODE returns to FETCH with all write enables 0.
REQ-040 reset asserted while in MEMREAD -> state FETCH on the next edge, with no reg_write pulse.
